// File: rtl/vga_pkg.sv
// Shared constants, direction encoding and the per-axis bounce step for the box renderer.
package vga_pkg;
  localparam int H_RES        = 640;
  localparam int V_RES        = 480;
  localparam int COUNTER_BITS = 10;
  localparam int CW           = COUNTER_BITS + 1;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;

  typedef enum logic {FWD = 1'b0, REV = 1'b1} dir_t;

  typedef struct packed {
    logic [COUNTER_BITS-1:0] pos;
    dir_t                    dir;
  } axis_t;

  // One bounce step on a single axis; widened by one bit so pos+size+step cannot wrap.
  function automatic axis_t bounce(axis_t cur, logic [CW-1:0] res,
                                   logic [CW-1:0] size, logic [CW-1:0] step);
    axis_t         nxt;
    logic [CW-1:0] p;
    nxt = cur;
    p   = {1'b0, cur.pos};
    if (cur.dir == FWD) begin
      if (p + size + step > res) begin
        nxt.pos = COUNTER_BITS'(res - size);
        nxt.dir = REV;
      end else begin
        nxt.pos = COUNTER_BITS'(p + step);
      end
    end else begin
      if (p < step) begin
        nxt.pos = '0;
        nxt.dir = FWD;
      end else begin
        nxt.pos = COUNTER_BITS'(p - step);
      end
    end
    return nxt;
  endfunction
endpackage

// File: rtl/vga_box_mover.sv
// Frame-tick detector plus independent X/Y bounce FSMs; the box moves only on the vblank tick.
//   state | meaning
//   FWD   | axis position increasing by STEP each tick
//   REV   | axis position decreasing by STEP each tick
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int BOX_SIZE = 32,
  parameter int STEP     = 2
) (
  input  logic                    clk_50MHz,
  input  logic                    clear,
  input  logic                    pix_en,
  input  logic                    run,
  input  logic [COUNTER_BITS-1:0] h_count,
  input  logic [COUNTER_BITS-1:0] v_count,
  output logic [COUNTER_BITS-1:0] box_x,
  output logic [COUNTER_BITS-1:0] box_y
);
  localparam logic [CW-1:0] HR = CW'(H_RES);
  localparam logic [CW-1:0] VR = CW'(V_RES);
  localparam logic [CW-1:0] SZ = CW'(BOX_SIZE);
  localparam logic [CW-1:0] ST = CW'(STEP);

  dir_t  x_dir, y_dir;
  logic  at_tick, at_tick_d, tick;
  axis_t nx, ny;

  assign at_tick = (v_count == COUNTER_BITS'(V_RES)) && (h_count == '0);
  // Edge-detect so a count held across several pix_en samples ticks only once.
  assign tick    = pix_en && at_tick && !at_tick_d;

  always_comb begin
    nx = bounce({box_x, x_dir}, HR, SZ, ST);
    ny = bounce({box_y, y_dir}, VR, SZ, ST);
  end

  always_ff @(posedge clk_50MHz) begin
    if (clear) begin
      at_tick_d <= 1'b0;
      box_x     <= '0;
      box_y     <= '0;
      x_dir     <= FWD;
      y_dir     <= FWD;
    end else if (pix_en) begin
      at_tick_d <= at_tick;
      if (tick && run) begin
        box_x <= nx.pos;
        x_dir <= nx.dir;
        box_y <= ny.pos;
        y_dir <= ny.dir;
      end
    end
  end
endmodule

// File: rtl/vga_box_renderer.sv
// Two-stage pixel pipeline: hit-test against the moving box, then colour mux with aligned syncs.
module vga_box_renderer
  import vga_pkg::*;
#(
  parameter int          BOX_SIZE  = 32,
  parameter int          STEP      = 2,
  parameter int          BORDER    = 1,
  parameter logic [23:0] BOX_COLOR = 24'hFF0000,
  parameter logic [23:0] BG_COLOR  = 24'h000040
) (
  input  logic                    clk_50MHz,
  input  logic                    clear,
  input  logic                    pix_en,
  input  logic                    run,
  input  logic [COUNTER_BITS-1:0] h_count,
  input  logic [COUNTER_BITS-1:0] v_count,
  input  logic                    bright,
  input  logic                    h_sync,
  input  logic                    v_sync,
  output logic [7:0]              vga_r,
  output logic [7:0]              vga_g,
  output logic [7:0]              vga_b,
  output logic                    vga_hs,
  output logic                    vga_vs,
  output logic                    vga_blank_n
);
  localparam logic [CW-1:0] SZ = CW'(BOX_SIZE);
  localparam logic [CW-1:0] BD = CW'(BORDER);

  logic [COUNTER_BITS-1:0] box_x, box_y;
  logic [CW-1:0]           h, v, x0, y0;
  logic                    in_x, in_y, edge_x, edge_y, in_box, in_border;
  logic                    s1_bright, s1_hs, s1_vs, s1_in_box, s1_in_border;

  vga_box_mover #(.BOX_SIZE(BOX_SIZE), .STEP(STEP)) u_mover (
    .clk_50MHz (clk_50MHz),
    .clear     (clear),
    .pix_en    (pix_en),
    .run       (run),
    .h_count   (h_count),
    .v_count   (v_count),
    .box_x     (box_x),
    .box_y     (box_y)
  );

  assign h  = {1'b0, h_count};
  assign v  = {1'b0, v_count};
  assign x0 = {1'b0, box_x};
  assign y0 = {1'b0, box_y};

  assign in_x      = (h >= x0) && (h < x0 + SZ);
  assign in_y      = (v >= y0) && (v < y0 + SZ);
  assign edge_x    = (h < x0 + BD) || (h >= x0 + SZ - BD);
  assign edge_y    = (v < y0 + BD) || (v >= y0 + SZ - BD);
  assign in_box    = in_x && in_y;
  assign in_border = in_box && (edge_x || edge_y);

  always_ff @(posedge clk_50MHz) begin
    if (clear) begin
      s1_bright    <= 1'b0;
      s1_hs        <= 1'b1;
      s1_vs        <= 1'b1;
      s1_in_box    <= 1'b0;
      s1_in_border <= 1'b0;
      {vga_r, vga_g, vga_b} <= BLACK;
      vga_hs       <= 1'b1;
      vga_vs       <= 1'b1;
      vga_blank_n  <= 1'b0;
    end else if (pix_en) begin
      s1_bright    <= bright;
      s1_hs        <= h_sync;
      s1_vs        <= v_sync;
      s1_in_box    <= in_box;
      s1_in_border <= in_border;
      if (!s1_bright)        {vga_r, vga_g, vga_b} <= BLACK;
      else if (s1_in_border) {vga_r, vga_g, vga_b} <= WHITE;
      else if (s1_in_box)    {vga_r, vga_g, vga_b} <= BOX_COLOR;
      else                   {vga_r, vga_g, vga_b} <= BG_COLOR;
      vga_hs       <= s1_hs;
      vga_vs       <= s1_vs;
      vga_blank_n  <= s1_bright;
    end
  end
endmodule
